// File: rtl/spi_xfer_sequencer_pkg.sv
// rtl/spi_xfer_sequencer_pkg.sv - register map, CTRL bit indices and FSM encoding for spi_xfer_sequencer.
package spi_seq_pkg;

  localparam logic [2:0] REG_CMD   = 3'd0;
  localparam logic [2:0] REG_ADDR  = 3'd1;
  localparam logic [2:0] REG_LEN   = 3'd2;
  localparam logic [2:0] REG_WDATA = 3'd3;
  localparam logic [2:0] REG_RDATA = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_CMD,
    S_W_ADDR,
    S_W_LEN,
    S_W_DATA,
    S_W_CTRL,
    S_POLL_GAP,
    S_POLL,
    S_R_DATA,
    S_W_ABORT,
    S_RESP
  } seq_state_e;

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// rtl/spi_xfer_sequencer_if.sv - request/response and APB master signals of spi_xfer_sequencer.
interface spi_xfer_sequencer_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [31:0]           req_cmd_i;
  logic [31:0]           req_addr_i;
  logic [31:0]           req_len_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  busy_o;
  logic                  psel_o;
  logic                  penable_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic                  pwrite_o;
  logic [31:0]           pwdata_o;
  logic [31:0]           prdata_i;
  logic                  pready_i;

  modport master (
    input  req_valid_i, req_write_i, req_cmd_i, req_addr_i, req_len_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
    output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
    input  prdata_i, pready_i
  );

  modport slave (
    output req_valid_i, req_write_i, req_cmd_i, req_addr_i, req_len_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
    input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
    output prdata_i, pready_i
  );
endinterface

// File: rtl/spi_xfer_sequencer_apb_xfer_port.sv
// rtl/spi_xfer_sequencer_apb_xfer_port.sv - runs one APB transfer per request; SETUP is combinational
// on i_start so back-to-back transfers need no idle cycle between them.
module apb_xfer_port #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  input  logic [31:0]           i_wdata,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic [ADDR_WIDTH-1:0] o_paddr,
  output logic                  o_pwrite,
  output logic [31:0]           o_pwdata,
  input  logic [31:0]           i_prdata,
  input  logic                  i_pready
);
  logic r_access;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_access <= 1'b0;
    end else if (r_access) begin
      if (i_pready) r_access <= 1'b0;
    end else if (i_start) begin
      r_access <= 1'b1;
    end
  end

  assign o_psel    = i_start | r_access;
  assign o_penable = r_access;
  assign o_done    = r_access & i_pready;
  assign o_rdata   = i_prdata;
  assign o_paddr   = i_addr;
  assign o_pwrite  = i_write;
  assign o_pwdata  = i_wdata;
endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - APB master sequencing one SPI transaction through apb_spi_master.
// Optional poll timeout with abort: define SPI_XFER_SEQ_TIMEOUT_EN.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int POLL_GAP    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  spi_xfer_sequencer_if.master bus
);
  seq_state_e  r_state, w_next;
  logic        r_write;
  logic [31:0] r_cmd, r_addr, r_len, r_wdata;
  logic [31:0] r_gap_cnt, r_rsp_rdata;
  logic        w_start, w_pwrite, w_done, w_timeout;
  logic [2:0]  w_reg;
  logic [31:0] w_pwdata, w_rdata;

  apb_xfer_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_port (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_start   (w_start),
    .i_addr    (ADDR_WIDTH'(w_reg)),
    .i_write   (w_pwrite),
    .i_wdata   (w_pwdata),
    .o_done    (w_done),
    .o_rdata   (w_rdata),
    .o_psel    (bus.psel_o),
    .o_penable (bus.penable_o),
    .o_paddr   (bus.paddr_o),
    .o_pwrite  (bus.pwrite_o),
    .o_pwdata  (bus.pwdata_o),
    .i_prdata  (bus.prdata_i),
    .i_pready  (bus.pready_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_reg    = REG_CMD;
    w_pwrite = 1'b0;
    w_pwdata = '0;
    case (r_state)
      S_IDLE:   if (bus.req_valid_i) w_next = S_W_CMD;
      S_W_CMD: begin
        w_start = 1'b1; w_pwrite = 1'b1; w_reg = REG_CMD; w_pwdata = r_cmd;
        if (w_done) w_next = S_W_ADDR;
      end
      S_W_ADDR: begin
        w_start = 1'b1; w_pwrite = 1'b1; w_reg = REG_ADDR; w_pwdata = r_addr;
        if (w_done) w_next = S_W_LEN;
      end
      S_W_LEN: begin
        w_start = 1'b1; w_pwrite = 1'b1; w_reg = REG_LEN; w_pwdata = r_len;
        if (w_done) w_next = r_write ? S_W_DATA : S_W_CTRL;
      end
      S_W_DATA: begin
        w_start = 1'b1; w_pwrite = 1'b1; w_reg = REG_WDATA; w_pwdata = r_wdata;
        if (w_done) w_next = S_W_CTRL;
      end
      S_W_CTRL: begin
        w_start = 1'b1; w_pwrite = 1'b1; w_reg = REG_CTRL;
        w_pwdata[CTRL_START] = 1'b1;
        if (w_done) w_next = (POLL_GAP == 0) ? S_POLL : S_POLL_GAP;
      end
      S_POLL_GAP: begin
        if (w_timeout)            w_next = S_W_ABORT;
        else if (r_gap_cnt == '0) w_next = S_POLL;
      end
      S_POLL: begin
        w_start = 1'b1; w_reg = REG_CTRL;
        // A poll already on the bus always completes before a timeout is acted on.
        if (w_done) begin
          if (!w_rdata[CTRL_BUSY]) w_next = r_write ? S_RESP : S_R_DATA;
          else if (w_timeout)      w_next = S_W_ABORT;
          else                     w_next = (POLL_GAP == 0) ? S_POLL : S_POLL_GAP;
        end
      end
      S_R_DATA: begin
        w_start = 1'b1; w_reg = REG_RDATA;
        if (w_done) w_next = S_RESP;
      end
      S_W_ABORT: begin
        w_start = 1'b1; w_pwrite = 1'b1; w_reg = REG_CTRL;
        if (w_done) w_next = S_RESP;
      end
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_write     <= 1'b0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_wdata     <= '0;
      r_gap_cnt   <= '0;
      r_rsp_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && bus.req_valid_i) begin
        r_write <= bus.req_write_i;
        r_cmd   <= bus.req_cmd_i;
        r_addr  <= bus.req_addr_i;
        r_len   <= bus.req_len_i;
        r_wdata <= bus.req_wdata_i;
      end
      if (w_next == S_POLL_GAP && r_state != S_POLL_GAP)
        r_gap_cnt <= 32'(POLL_GAP - 1);
      else if (r_state == S_POLL_GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - 32'd1;
      if (w_next == S_RESP && r_state != S_RESP)
        r_rsp_rdata <= (r_state == S_R_DATA) ? w_rdata : '0;
    end
  end

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
  logic [31:0] r_poll_cnt;
  logic        r_rsp_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_poll_cnt <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (r_state == S_W_CTRL && w_done)
        r_poll_cnt <= '0;
      else if (r_state == S_POLL_GAP || r_state == S_POLL)
        r_poll_cnt <= r_poll_cnt + 32'd1;
      if (w_next == S_RESP && r_state != S_RESP)
        r_rsp_err <= (r_state == S_W_ABORT);
    end
  end

  assign w_timeout     = (r_poll_cnt >= 32'(TIMEOUT_CYC));
  assign bus.rsp_err_o = (r_state == S_RESP) & r_rsp_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_timeout        = 1'b0;
  assign bus.rsp_err_o    = 1'b0;
`endif

  assign bus.req_ready_o = (r_state == S_IDLE);
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.rsp_valid_o = (r_state == S_RESP);
  assign bus.rsp_rdata_o = r_rsp_rdata;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - self-checking bench for spi_xfer_sequencer with an APB slave model.
// Define SPI_XFER_SEQ_TIMEOUT_EN to also exercise the poll timeout.
module tb_spi_xfer_sequencer;
  localparam int AW = 4;
  localparam int G  = 2;
  localparam int TO = 16;

  typedef struct { logic [3:0] addr; bit wr; logic [31:0] data; } acc_t;
  typedef struct {
    bit wr; logic [31:0] cmd, addr, len, wdata, rdata;
    int nbusy; int waitc; logic [31:0] exp_rdata; bit exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cfg_wait = 0;
  int          busy_left = 0;
  int          stab_err = 0;
  bit          stuck = 1'b0;
  logic [31:0] cfg_rdata = '0;
  acc_t        log_q[$];
  acc_t        exp_q[$];
  vec_t        vecs[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_xfer_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  spi_xfer_sequencer #(.ADDR_WIDTH(AW), .POLL_GAP(G), .TIMEOUT_CYC(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  // APB slave: configurable wait states, CTRL busy for a set number of reads, fixed RDATA.
  initial begin
    int          wl;
    logic [3:0]  sa;
    logic        sw;
    logic [31:0] sd, v;
    wl = 0; sa = '0; sw = 1'b0; sd = '0;
    bus.pready_i = 1'b0;
    bus.prdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.psel_o) begin
        bus.pready_i = 1'b0;
      end else if (!bus.penable_o) begin
        sa = bus.paddr_o; sw = bus.pwrite_o; sd = bus.pwdata_o;
        wl = cfg_wait;
        bus.pready_i = 1'b0;
      end else begin
        if (bus.paddr_o !== sa || bus.pwrite_o !== sw || (sw && bus.pwdata_o !== sd))
          stab_err++;
        if (wl > 0) begin
          wl--;
          bus.pready_i = 1'b0;
        end else begin
          bus.pready_i = 1'b1;
          if (sw) begin
            log_q.push_back('{sa, 1'b1, sd});
          end else begin
            v = $urandom;
            if (sa == 4'd5) begin
              v[1] = stuck || (busy_left > 0);
              if (busy_left > 0) busy_left--;
            end else if (sa == 4'd4) begin
              v = cfg_rdata;
            end
            bus.prdata_i = v;
            log_q.push_back('{sa, 1'b0, v});
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input vec_t v);
    exp_q.delete();
    exp_q.push_back('{4'd0, 1'b1, v.cmd});
    exp_q.push_back('{4'd1, 1'b1, v.addr});
    exp_q.push_back('{4'd2, 1'b1, v.len});
    if (v.wr) exp_q.push_back('{4'd3, 1'b1, v.wdata});
    exp_q.push_back('{4'd5, 1'b1, 32'd1});
    for (int i = 0; i <= v.nbusy; i++) exp_q.push_back('{4'd5, 1'b0, 32'd0});
    if (!v.wr) exp_q.push_back('{4'd4, 1'b0, 32'd0});
  endtask

  function automatic int lat_model(input vec_t v);
    int acc;
    acc = (v.wr ? 5 : 4) + v.nbusy + 1 + (v.wr ? 0 : 1);
    return 1 + acc * (2 + v.waitc) + (v.nbusy + 1) * G;
  endfunction

  task automatic setup_slave(input vec_t v);
    cfg_wait  = v.waitc;
    busy_left = v.nbusy;
    cfg_rdata = v.rdata;
    stuck     = 1'b0;
    stab_err  = 0;
    log_q.delete();
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_write_i = v.wr;
    bus.req_cmd_i   = v.cmd;
    bus.req_addr_i  = v.addr;
    bus.req_len_i   = v.len;
    bus.req_wdata_i = v.wdata;
  endtask

  task automatic wait_rsp(input string nm, output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.rsp_valid_o === 1'b1) begin ok = 1'b1; t = cyc; break; end
      @(negedge clk);
    end
    chk({nm, "_rsp_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic cmp_log(input string nm);
    int bad;
    bad = -1;
    chk({nm, "_nacc"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      if (bad < 0 && (log_q[i].addr !== exp_q[i].addr || log_q[i].wr != exp_q[i].wr ||
                      (exp_q[i].wr && log_q[i].data !== exp_q[i].data)))
        bad = i;
    chk({nm, "_first_bad_acc"}, bad, -1);
  endtask

  task automatic post_rsp(input vec_t v, input string nm, input int lat);
    chk({nm, "_lat"}, lat, lat_model(v));
    chk({nm, "_rdata"}, bus.rsp_rdata_o, v.exp_rdata);
    chk({nm, "_err"}, 32'(bus.rsp_err_o), 32'(v.exp_err));
    cmp_log(nm);
    chk({nm, "_stable"}, stab_err, 0);
    @(negedge clk);
    chk({nm, "_after"}, {29'd0, bus.rsp_valid_o, bus.req_ready_o, bus.busy_o}, 32'd2);
    chk({nm, "_hold"}, bus.rsp_rdata_o, v.exp_rdata);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int t0, t1;
    bit ok;
    setup_slave(v);
    model(v);
    @(negedge clk);
    drive_req(v);
    bus.req_valid_i = 1'b1;
    chk({nm, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    t0 = cyc;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk({nm, "_busy"}, {30'd0, bus.busy_o, bus.req_ready_o}, 32'd2);
    wait_rsp(nm, t1, ok);
    if (ok) post_rsp(v, nm, t1 - t0);
  endtask

  initial begin
    vec_t v, v2;
    int   t0, t1;
    bit   ok, found, seen;

    vecs[0] = '{1'b1, 32'h02, 32'h100, 32'd4, 32'habcd1234, 32'h0, 2, 0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h03, 32'h100, 32'd4, 32'hdeadbeef, 32'h5a5a00ff, 0, 0, 32'h5a5a00ff, 1'b0};
    vecs[2] = '{1'b1, 32'h02, 32'h40, 32'd8, 32'h13572468, 32'h0, 1, 3, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 32'h0b, 32'h80, 32'd2, 32'h0, 32'hc0ffee11, 1, 3, 32'hc0ffee11, 1'b0};

    bus.req_valid_i = 1'b0;
    drive_req(vecs[0]);

    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_apb", {25'd0, bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o}, 32'd0);
    chk("rst_pwdata", bus.pwdata_o, 32'd0);
    chk("rst_rsp", {29'd0, bus.rsp_valid_o, bus.rsp_err_o, bus.busy_o}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Request held valid through a transaction: next one accepted only after rsp_valid.
    v  = vecs[0];
    v2 = vecs[1];
    v2.addr = 32'h200;
    setup_slave(v);
    model(v);
    @(negedge clk);
    drive_req(v);
    bus.req_valid_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    drive_req(v2);
    wait_rsp("b2b_a", t1, ok);
    if (ok) begin
      chk("b2b_ready_in_rsp", 32'(bus.req_ready_o), 32'd0);
      post_rsp(v, "b2b_a", t1 - t0);
      t0 = cyc;
      setup_slave(v2);
      model(v2);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      chk("b2b_b_busy", 32'(bus.busy_o), 32'd1);
      wait_rsp("b2b_b", t1, ok);
      if (ok) post_rsp(v2, "b2b_b", t1 - t0);
    end
    bus.req_valid_i = 1'b0;

    for (int i = 0; i < 24; i++) begin
      v.wr        = 1'($urandom_range(0, 1));
      v.cmd       = $urandom;
      v.addr      = $urandom;
      v.len       = $urandom;
      v.wdata     = $urandom;
      v.rdata     = $urandom;
      v.nbusy     = $urandom_range(0, 2);
      v.waitc     = $urandom_range(0, 1);
      v.exp_rdata = v.wr ? 32'd0 : v.rdata;
      v.exp_err   = 1'b0;
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Reset during the LEN access: bus drops at once, no response, idle afterwards.
    v = vecs[2];
    setup_slave(v);
    @(negedge clk);
    drive_req(v);
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.psel_o && bus.penable_o && bus.paddr_o == 4'd2) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_mid_found_len", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_apb_drop", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", {30'd0, bus.req_ready_o, bus.busy_o}, 32'd2);
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen = 1'b1;
    end
    chk("rst_mid_no_rsp", 32'(seen), 32'd0);
    run_txn(vecs[1], "post_rst");

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
    v = vecs[0];
    setup_slave(v);
    stuck = 1'b1;
    @(negedge clk);
    drive_req(v);
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    wait_rsp("tmo", t1, ok);
    if (ok) begin
      chk("tmo_err", 32'(bus.rsp_err_o), 32'd1);
      chk("tmo_rdata", bus.rsp_rdata_o, 32'd0);
      chk("tmo_nacc_min", 32'(log_q.size() >= 7), 32'd1);
      if (log_q.size() >= 7) begin
        chk("tmo_start_write", {log_q[4].addr, 27'd0, log_q[4].wr}, {4'd5, 27'd0, 1'b1});
        chk("tmo_last_addr", log_q[log_q.size()-1].addr, 4'd5);
        chk("tmo_last_wr", 32'(log_q[log_q.size()-1].wr), 32'd1);
        chk("tmo_last_data", log_q[log_q.size()-1].data, 32'd0);
      end
      @(negedge clk);
      chk("tmo_after", {30'd0, bus.rsp_valid_o, bus.req_ready_o}, 32'd1);
    end
    stuck = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
